// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side drain into a 2-entry skid-buffered valid/ready stream
module fifo_rd_stream #(
  parameter int DATASIZE = 8,
  parameter int BURSTLEN = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                en,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  output logic                rinc,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATASIZE-1:0] m_data,
  output logic                m_last,
  output logic [15:0]         rd_count
);

  localparam int BW = (BURSTLEN > 1) ? $clog2(BURSTLEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURSTLEN - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_e;

  occ_e                occ_q, occ_d;
  logic                run_q, run_d;
  logic [DATASIZE-1:0] buf0_q, buf0_d;
  logic [DATASIZE-1:0] buf1_q, buf1_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [15:0]         rd_count_q, rd_count_d;

  logic pop;
  logic accept;

  // Pop strobe depends only on registered state plus en/rempty, never on m_ready
  assign rinc     = run_q & en & ~rempty & (occ_q != S_TWO);
  assign pop      = rinc;
  assign m_valid  = (occ_q != S_EMPTY);
  assign accept   = m_valid & m_ready;
  assign m_data   = buf0_q;
  assign m_last   = m_valid & (beat_q == LAST_BEAT);
  assign rd_count = rd_count_q;

  // Next-state for occupancy FSM, skid buffer, burst beat and pop counter
  always_comb begin
    occ_d      = occ_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    beat_d     = beat_q;
    rd_count_d = rd_count_q;
    run_d      = 1'b1;

    case (occ_q)
      S_EMPTY: begin
        if (pop) begin
          buf0_d = rdata;
          occ_d  = S_ONE;
        end
      end
      S_ONE: begin
        if (pop && accept) begin
          // head leaves while the new word takes its place
          buf0_d = rdata;
        end else if (pop) begin
          buf1_d = rdata;
          occ_d  = S_TWO;
        end else if (accept) begin
          occ_d = S_EMPTY;
        end
      end
      S_TWO: begin
        // rinc is forced low here, so only the accept path exists
        if (accept) begin
          buf0_d = buf1_q;
          occ_d  = S_ONE;
        end
      end
      default: begin
        occ_d = S_EMPTY;
      end
    endcase

    if (accept) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
    end

    if (pop) begin
      rd_count_d = rd_count_q + 16'd1;
    end
  end

  // State registers; reset discards any buffered words
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ_q      <= S_EMPTY;
      run_q      <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      beat_q     <= '0;
      rd_count_q <= 16'd0;
    end else begin
      occ_q      <= occ_d;
      run_q      <= run_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      beat_q     <= beat_d;
      rd_count_q <= rd_count_d;
    end
  end

endmodule
